// File: rtl/mem_stage_pkg.sv
// Shared encodings for the riscx memory/write-back stage.
// Widths follow the project-wide XLEN/REG_IDX_WIDTH macros when they exist.
// Holds access-size codes, FSM state codes and the alignment helper.
`ifndef XLEN
`define XLEN 32
`endif

`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

package mem_stage_pkg;

    localparam int MEM_XLEN = `XLEN;

    localparam int MEM_REG_IDX_WIDTH = `REG_IDX_WIDTH;

    // Access size encodings; 2'b11 is illegal and handled as a word.
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    // FSM state encodings.
    localparam logic [1:0] MEM_ST_IDLE = 2'b00;
    localparam logic [1:0] MEM_ST_REQ  = 2'b01;
    localparam logic [1:0] MEM_ST_RESP = 2'b10;

    // True when the access does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_B: return 1'b0;
            MEM_SIZE_H: return addr_lo[0];
            default:    return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and memory (slave).
// req/gnt for the address phase, rvalid/rdata for the load response.
// Signals keep the stage's port names so waveforms read the same at both ends.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int XLEN = MEM_XLEN
);
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [3:0]      dmem_be_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = MEM_XLEN
) (
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_ld_raw,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_st_data,
    output logic [XLEN-1:0] o_ld_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: enables follow the addressed lane, data is replicated on every lane.
    always_comb begin
        o_be      = 4'b1111;
        o_st_data = i_st_data;
        case (i_size)
            MEM_SIZE_B: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_st_data = {(XLEN/8){i_st_data[7:0]}};
            end
            MEM_SIZE_H: begin
                o_be      = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_st_data = {(XLEN/16){i_st_data[15:0]}};
            end
            default: begin
                o_be      = 4'b1111;
                o_st_data = i_st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend it.
    always_comb begin
        w_byte = i_ld_raw[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_ld_raw[7:0];
            2'd1:    w_byte = i_ld_raw[15:8];
            2'd2:    w_byte = i_ld_raw[23:16];
            default: w_byte = i_ld_raw[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
        case (i_size)
            MEM_SIZE_B: o_ld_data = {{(XLEN-8){~i_unsigned & w_byte[7]}}, w_byte};
            MEM_SIZE_H: o_ld_data = {{(XLEN-16){~i_unsigned & w_half[15]}}, w_half};
            default:    o_ld_data = i_ld_raw;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory/write-back stage: ALU results write back in 1 cycle; loads/stores go over req/gnt/rvalid.
// Latency: ALU op 1 cycle; load = accept + req cycles until gnt + resp cycles until rvalid + 1.
// Backpressure: stall_o is high whenever a bus transaction is outstanding (MEM_MISALIGN_TRAP_EN adds misalign_o).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN          = MEM_XLEN,
    parameter int REG_IDX_WIDTH = MEM_REG_IDX_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    input  logic                     ex_load_i,
    input  logic                     ex_store_i,
    input  logic [1:0]               ex_size_i,
    input  logic                     ex_unsigned_i,
    input  logic [XLEN-1:0]          ex_alu_res_i,
    input  logic [XLEN-1:0]          ex_rs2_rdata_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
    input  logic                     ex_rd_en_i,
    output logic                     stall_o,
    mem_stage_if.master              dmem,
    output logic                     wb_rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                     misalign_o,
`endif
    output logic [XLEN-1:0]          wb_rd_wdata_o
);
    logic [1:0]               r_state;
    logic                     r_req;
    logic                     r_we;
    logic [XLEN-1:0]          r_addr;
    logic [3:0]               r_be;
    logic [XLEN-1:0]          r_wdata;
    logic [1:0]               r_size;
    logic [1:0]               r_lane;
    logic                     r_unsigned;
    logic [REG_IDX_WIDTH-1:0] r_rd_idx;
    logic                     r_rd_en;
    logic                     r_wb_en;
    logic [REG_IDX_WIDTH-1:0] r_wb_idx;
    logic [XLEN-1:0]          r_wb_wdata;

    logic                     w_idle;
    logic                     w_mem_op;
    logic                     w_misalign;
    logic [1:0]               w_size;
    logic [1:0]               w_lane;
    logic                     w_unsigned;
    logic [3:0]               w_be;
    logic [XLEN-1:0]          w_st_data;
    logic [XLEN-1:0]          w_ld_data;

    assign w_idle   = (r_state == MEM_ST_IDLE);
    assign w_mem_op = ex_load_i | ex_store_i;

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_misalign = is_misaligned(ex_size_i, ex_alu_res_i[1:0]);
    assign misalign_o = r_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // In IDLE the aligner encodes the incoming store; afterwards it decodes the captured load.
    assign w_size     = w_idle ? ex_size_i          : r_size;
    assign w_lane     = w_idle ? ex_alu_res_i[1:0]  : r_lane;
    assign w_unsigned = w_idle ? ex_unsigned_i      : r_unsigned;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .i_size     (w_size),
        .i_addr_lo  (w_lane),
        .i_unsigned (w_unsigned),
        .i_st_data  (ex_rs2_rdata_i),
        .i_ld_raw   (dmem.dmem_rdata_i),
        .o_be       (w_be),
        .o_st_data  (w_st_data),
        .o_ld_data  (w_ld_data)
    );

    // FSM, request registers and write-back port; write enable is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MEM_ST_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_size     <= MEM_SIZE_B;
            r_lane     <= '0;
            r_unsigned <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_en    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_wdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_wb_en <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                MEM_ST_IDLE: begin
                    if (ex_valid_i && w_mem_op) begin
                        if (w_misalign) begin
`ifdef MEM_MISALIGN_TRAP_EN
                            r_misalign <= 1'b1;
`endif
                        end else begin
                            r_state    <= MEM_ST_REQ;
                            r_req      <= 1'b1;
                            // Load wins if both flags are set.
                            r_we       <= ex_store_i & ~ex_load_i;
                            r_addr     <= {ex_alu_res_i[XLEN-1:2], 2'b00};
                            r_be       <= w_be;
                            r_wdata    <= w_st_data;
                            r_size     <= ex_size_i;
                            r_lane     <= ex_alu_res_i[1:0];
                            r_unsigned <= ex_unsigned_i;
                            r_rd_idx   <= ex_rd_idx_i;
                            r_rd_en    <= ex_rd_en_i;
                        end
                    end else if (ex_valid_i) begin
                        r_wb_en    <= ex_rd_en_i && (ex_rd_idx_i != '0);
                        r_wb_idx   <= ex_rd_idx_i;
                        r_wb_wdata <= ex_alu_res_i;
                    end
                end
                MEM_ST_REQ: begin
                    if (dmem.dmem_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? MEM_ST_IDLE : MEM_ST_RESP;
                    end
                end
                MEM_ST_RESP: begin
                    if (dmem.dmem_rvalid_i) begin
                        r_state    <= MEM_ST_IDLE;
                        r_wb_en    <= r_rd_en && (r_rd_idx != '0);
                        r_wb_idx   <= r_rd_idx;
                        r_wb_wdata <= w_ld_data;
                    end
                end
                default: r_state <= MEM_ST_IDLE;
            endcase
        end
    end

    assign stall_o            = ~w_idle;
    assign dmem.dmem_req_o    = r_req;
    assign dmem.dmem_we_o     = r_we;
    assign dmem.dmem_addr_o   = r_addr;
    assign dmem.dmem_be_o     = r_be;
    assign dmem.dmem_wdata_o  = r_wdata;
    assign wb_rd_en_o         = r_wb_en;
    assign wb_rd_idx_o        = r_wb_idx;
    assign wb_rd_wdata_o      = r_wb_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected bus requests and write-backs are queued at issue time.
// A negedge monitor pops and compares whenever the DUT grants a request or pulses the write port.
// Direct checks cover reset values, stall length and the no-write-back cases.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0, ex_unsigned = 1'b0, ex_rd_en = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic [31:0] ex_alu_res = '0, ex_rs2 = '0;
    logic [4:0]  ex_rd_idx = '0;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage_if #(.XLEN(32)) u_if ();

    always #5 clk = ~clk;

    mem_stage #(.XLEN(32), .REG_IDX_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid),
        .ex_load_i      (ex_load),
        .ex_store_i     (ex_store),
        .ex_size_i      (ex_size),
        .ex_unsigned_i  (ex_unsigned),
        .ex_alu_res_i   (ex_alu_res),
        .ex_rs2_rdata_i (ex_rs2),
        .ex_rd_idx_i    (ex_rd_idx),
        .ex_rd_en_i     (ex_rd_en),
        .stall_o        (stall),
        .dmem           (u_if.master),
        .wb_rd_en_o     (wb_en),
        .wb_rd_idx_o    (wb_idx),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o     (misalign),
`endif
        .wb_rd_wdata_o  (wb_wdata)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_be;
        logic        chk_wd;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    int n_vec = 0;
    int n_err = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: stall accounting plus scoreboard pops for granted requests and write-backs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) stall_cnt++;
            if (wb_en) begin
                if (wb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_wb: got idx %0d data 0x%08h expected no write", wb_idx, wb_wdata);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_idx", {27'd0, wb_idx}, {27'd0, e.idx});
                    chk("wb_data", wb_wdata, e.data);
                end
            end
            if (u_if.dmem_req_o && u_if.dmem_gnt_i) begin
                if (req_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_req: got addr 0x%08h expected no request", u_if.dmem_addr_o);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    chk("req_addr", u_if.dmem_addr_o, r.addr);
                    chk("req_we", {31'd0, u_if.dmem_we_o}, {31'd0, r.we});
                    if (r.chk_be) chk("req_be", {28'd0, u_if.dmem_be_o}, {28'd0, r.be});
                    if (r.chk_wd) chk("req_wdata", u_if.dmem_wdata_o, r.wdata);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_req"}, {31'd0, u_if.dmem_req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, u_if.dmem_we_o}, 32'd0);
        chk({tag, "_addr"}, u_if.dmem_addr_o, 32'd0);
        chk({tag, "_be"}, {28'd0, u_if.dmem_be_o}, 32'd0);
        chk({tag, "_wdata"}, u_if.dmem_wdata_o, 32'd0);
        chk({tag, "_wb_en"}, {31'd0, wb_en}, 32'd0);
        chk({tag, "_wb_idx"}, {27'd0, wb_idx}, 32'd0);
        chk({tag, "_wb_wdata"}, wb_wdata, 32'd0);
    endtask

    // Present one instruction for exactly one cycle (DUT must be IDLE).
    task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd, input logic rden);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = sz; ex_unsigned = uns;
        ex_alu_res = a; ex_rs2 = rs2; ex_rd_idx = rd; ex_rd_en = rden;
        stall_cnt = 0;
        step();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    endtask

    // Memory model: gnt after gnt_dly idle request cycles, then rvalid after rv_dly cycles.
    task automatic bus(input int gnt_dly, input bit is_load, input int rv_dly, input logic [31:0] rdata);
        repeat (gnt_dly) step();
        u_if.dmem_gnt_i = 1'b1;
        step();
        u_if.dmem_gnt_i = 1'b0;
        if (is_load) begin
            repeat (rv_dly) step();
            u_if.dmem_rvalid_i = 1'b1;
            u_if.dmem_rdata_i  = rdata;
            step();
            u_if.dmem_rvalid_i = 1'b0;
        end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        u_if.dmem_gnt_i = 1'b0;
        u_if.dmem_rvalid_i = 1'b0;
        u_if.dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // ALU op: write-back next cycle, never stalls.
        wb_q.push_back('{5'd5, 32'h0000_1234});
        drive_op(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
        step(); step();

        // LB signed from lane 3, gnt after two waiting cycles, rvalid right after.
        req_q.push_back('{32'h100, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd7, 32'hFFFF_FF80});
        drive_op(1'b1, 1'b0, MEM_SIZE_B, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1);
        bus(2, 1'b1, 0, 32'h80FF_FFFF);
        chk("lb_stall_cycles", stall_cnt, 32'd4);

        // SH to upper half, gnt in the first request cycle, no write-back.
        req_q.push_back('{32'h200, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 1'b1});
        drive_op(1'b0, 1'b1, MEM_SIZE_H, 1'b0, 32'h202, 32'hABCD_1234, 5'd9, 1'b1);
        bus(0, 1'b0, 0, 32'h0);
        chk("sh_stall_cycles", stall_cnt, 32'd1);

        // LHU into x0: no write-back; same access to x3 exposes the extracted value.
        req_q.push_back('{32'h0, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        drive_op(1'b1, 1'b0, MEM_SIZE_H, 1'b1, 32'h2, 32'h0, 5'd0, 1'b1);
        bus(1, 1'b1, 1, 32'h8001_5555);
        req_q.push_back('{32'h0, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd3, 32'h0000_8001});
        drive_op(1'b1, 1'b0, MEM_SIZE_H, 1'b1, 32'h2, 32'h0, 5'd3, 1'b1);
        bus(0, 1'b1, 0, 32'h8001_5555);

        // LH signed low half, LBU lane 1, LB positive lane 2.
        req_q.push_back('{32'h40, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd4, 32'hFFFF_F00D});
        drive_op(1'b1, 1'b0, MEM_SIZE_H, 1'b0, 32'h40, 32'h0, 5'd4, 1'b1);
        bus(0, 1'b1, 0, 32'h1234_F00D);
        req_q.push_back('{32'h44, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd6, 32'h0000_00AB});
        drive_op(1'b1, 1'b0, MEM_SIZE_B, 1'b1, 32'h45, 32'h0, 5'd6, 1'b1);
        bus(0, 1'b1, 0, 32'h0000_AB00);
        req_q.push_back('{32'h48, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd8, 32'h0000_007F});
        drive_op(1'b1, 1'b0, MEM_SIZE_B, 1'b0, 32'h4A, 32'h0, 5'd8, 1'b1);
        bus(0, 1'b1, 0, 32'h007F_0000);

        // LW at an unaligned address.
`ifdef MEM_MISALIGN_TRAP_EN
        drive_op(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_req", {31'd0, u_if.dmem_req_o}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        step();
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        step();
`else
        req_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0, 1'b1, 1'b0});
        wb_q.push_back('{5'd9, 32'hDEAD_BEEF});
        drive_op(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1);
        bus(1, 1'b1, 0, 32'hDEAD_BEEF);
`endif

        // SB lane 1, and a store with the illegal size code acting as a word.
        req_q.push_back('{32'h4, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b1});
        drive_op(1'b0, 1'b1, MEM_SIZE_B, 1'b0, 32'h5, 32'h0000_00A5, 5'd1, 1'b1);
        bus(0, 1'b0, 0, 32'h0);
        req_q.push_back('{32'h8, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b1});
        drive_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h8, 32'hCAFE_F00D, 5'd1, 1'b1);
        bus(1, 1'b0, 0, 32'h0);

        // Load and store both set: treated as a load.
        req_q.push_back('{32'hC, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        wb_q.push_back('{5'd10, 32'h1122_3344});
        drive_op(1'b1, 1'b1, MEM_SIZE_W, 1'b0, 32'hC, 32'h9999_9999, 5'd10, 1'b1);
        bus(0, 1'b1, 0, 32'h1122_3344);

        // ALU ops that must not write: rd=x0, and rd_en=0.
        drive_op(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'h7777, 32'h0, 5'd0, 1'b1);
        chk("alu_x0_wb_en", {31'd0, wb_en}, 32'd0);
        drive_op(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'h8888, 32'h0, 5'd7, 1'b0);
        chk("alu_noen_wb_en", {31'd0, wb_en}, 32'd0);
        step();

        // Back-to-back: ALU op held during a store is taken only once IDLE is registered.
        req_q.push_back('{32'h10, 1'b1, 4'b1111, 32'h0000_0001, 1'b1, 1'b1});
        wb_q.push_back('{5'd11, 32'h0000_0055});
        drive_op(1'b0, 1'b1, MEM_SIZE_W, 1'b0, 32'h10, 32'h1, 5'd2, 1'b1);
        ex_valid = 1'b1; ex_alu_res = 32'h55; ex_rd_idx = 5'd11; ex_rd_en = 1'b1;
        u_if.dmem_gnt_i = 1'b1;
        step();
        u_if.dmem_gnt_i = 1'b0;
        chk("b2b_stall_drop", {31'd0, stall}, 32'd0);
        chk("b2b_not_early", {31'd0, wb_en}, 32'd0);
        step();
        ex_valid = 1'b0;
        chk("b2b_wb_en", {31'd0, wb_en}, 32'd1);
        step(); step();

        // Reset while waiting for load data; late rvalid must be ignored.
        req_q.push_back('{32'h20, 1'b0, 4'b0, 32'h0, 1'b0, 1'b0});
        drive_op(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h20, 32'h0, 5'd12, 1'b1);
        u_if.dmem_gnt_i = 1'b1;
        step();
        u_if.dmem_gnt_i = 1'b0;
        chk("resp_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        rst_n = 1'b1;
        step();
        u_if.dmem_rvalid_i = 1'b1;
        u_if.dmem_rdata_i = 32'hFFFF_FFFF;
        step();
        u_if.dmem_rvalid_i = 1'b0;
        step();
        chk_all_zero("post_reset");

        repeat (3) step();
        chk("wb_left", wb_q.size(), 32'd0);
        chk("req_left", req_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
